sseg_capture: RTL and testbench
===============================

Name: sseg_capture

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder. It monitors a time-multiplexed seven-segment display bus (digit enables plus a segment bus) and decodes each digit back to its hex value and decimal point.
- Only patterns that hold stable for a programmable dwell are captured. A full-frame strobe and an error flag are raised once every digit has been seen.
- Used as a loopback/self-test observer alongside the display multiplexer on the Elbert V2 board.

Parameters:
N_DIGITS, 3, number of multiplexed digits (width of an_in).
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (legal range 2..255).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
an_in  input  N_DIGITS  digit enables, active-low; bit i selects digit i
sseg_in  input  8  segment bus, active-low; bit7 = dp, bits6..0 = a,b,c,d,e,f,g
hex_out  output  4*N_DIGITS  decoded hex value; digit i in bits [4i+3:4i]
dp_out  output  N_DIGITS  captured raw dp bit per digit (0 = lit)
digit_valid  output  N_DIGITS  1 = last capture of digit i was a legal pattern
frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse
frame_err  output  1  1 = at least one illegal pattern captured in the last completed frame

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high.
- Values on reset:
  - hex_out = 0, dp_out = all 1, digit_valid = 0, frame_done = 0, frame_err = 0.
  - Sample registers: an = all 1, sseg = all 1.
  - Stability counter = 0, captured flag = 0, seen mask = 0, bad mask = 0.
- Reset mid-frame discards any partial frame; no frame_done is issued for it.
- Input stage: an_in and sseg_in are registered every cycle (1 stage). key = {an_reg, sseg_reg}.
- A key is eligible only if exactly one bit of an_reg is 0. With zero or multiple digits active:
  - the counter clears to 0 and the captured flag clears;
  - nothing is captured.
- Stability counter:
  - If key equals the previous cycle's key and is eligible, the counter increments, saturating at STABLE_CYCLES-1.
  - Otherwise the counter goes to 0 and the captured flag clears.
- Capture:
  - Fires on the edge where the counter equals STABLE_CYCLES-1 and the captured flag is 0.
  - Sets the captured flag, so at most one capture per dwell.
  - Inputs held from cycle 0 produce updated outputs after the (STABLE_CYCLES+1)th rising edge.
  - A glitch of even one cycle restarts the dwell.
- Decode of sseg_reg[6:0] (active-low, a..g):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3
  - 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0000100=9, 0001000=A, 1100000=b
  - 0110001=C, 1000010=d, 0110000=E, 0111000=F
- On capture of digit i:
  - Legal pattern: hex_out slice i = decoded value, digit_valid[i] = 1.
  - Any other pattern (including blank 1111111): hex_out slice i is held, digit_valid[i] = 0, bad_mask[i] = 1.
  - In both cases dp_out[i] = sseg_reg[7] and seen[i] = 1.
- Frame completion:
  - On the cycle seen becomes all ones (including via the current capture), frame_done pulses for 1 cycle and frame_err <= |(bad_mask including the current capture).
  - seen and bad_mask clear in the same cycle.
  - frame_err holds until the next frame_done.
- Recapture of an already-seen digit within a frame overwrites its outputs. The seen bit stays 1 and no extra frame_done is issued.
- Digits may arrive in any order; the order does not matter.

Test Plan:
1. Reset, then an_in=110, sseg_in=8'b1_0010010 held 5 cycles, STABLE_CYCLES=4 -> hex_out[3:0]=2, dp_out[0]=1, digit_valid=001 after the 5th edge, frame_done=0.
2. Scan digits 0,1,2 with patterns 0000110, 0111000, 1100000 (dp bit 0 on digit 1), 6 cycles each -> hex_out=12'hBF3, dp_out=101, frame_done pulses once on the digit-2 capture edge, frame_err=0.
3. Same scan but digit 1 shows 1111111 -> digit_valid=101, digit 1 hex held at its prior value, frame_err=1 after frame_done.
4. Digit 0 pattern held 3 cycles, 1 glitch cycle, then 3 cycles (STABLE_CYCLES=4) -> no capture; digit_valid unchanged. Then 4 stable cycles -> capture.
5. an_in=100 (two active) or 111 held 20 cycles -> no output change, no frame_done.
6. Assert reset mid-frame after 2 of 3 digits captured -> all outputs return to reset values. A fresh 3-digit scan then yields exactly one frame_done.

Source files
------------

// File: rtl/sseg_capture.sv
`default_nettype none
// ============================================================================
// sseg_capture : observes a multiplexed 7-segment bus, decodes stable digits
// Revision 1.0 - initial release
// ============================================================================
module sseg_capture #(
  parameter int N_DIGITS      = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_DIGITS-1:0]   an_in,
  input  logic [7:0]            sseg_in,
  output logic [4*N_DIGITS-1:0] hex_out,
  output logic [N_DIGITS-1:0]   dp_out,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int                  KEY_W     = N_DIGITS + 8;
  localparam logic [7:0]          C_CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [N_DIGITS-1:0] C_ALL     = '1;

  // Returns {legal, hex}; input is active-low a..g with a in bit 6.
  function automatic logic [4:0] decode7(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [N_DIGITS-1:0]   an_q;
  logic [7:0]            sseg_q;
  logic [KEY_W-1:0]      key_prev_q;
  logic [7:0]            cnt_q, cnt_d;
  logic                  captured_q, captured_d;
  logic [N_DIGITS-1:0]   seen_q, seen_d;
  logic [N_DIGITS-1:0]   bad_q, bad_d;
  logic [4*N_DIGITS-1:0] hex_q, hex_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic [N_DIGITS-1:0]   valid_q, valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_err_q, frame_err_d;

  logic [KEY_W-1:0]      w_key;
  logic [N_DIGITS-1:0]   w_sel;
  logic                  w_eligible;
  logic                  w_same;
  logic                  w_capture;
  logic [4:0]            w_dec;
  logic [N_DIGITS-1:0]   w_seen_nx;
  logic [N_DIGITS-1:0]   w_bad_nx;

  assign w_key      = {an_q, sseg_q};
  assign w_sel      = ~an_q;
  assign w_eligible = $onehot(w_sel);
  assign w_same     = w_eligible && (w_key == key_prev_q);
  assign w_dec      = decode7(sseg_q[6:0]);

  // Dwell counter: the counter reaching its maximum on this edge is the
  // capture point, so outputs update STABLE_CYCLES+1 edges after the inputs.
  always_comb begin
    cnt_d      = 8'd0;
    captured_d = 1'b0;
    w_capture  = 1'b0;
    if (w_same) begin
      cnt_d      = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 8'd1;
      w_capture  = (cnt_d == C_CNT_MAX) && !captured_q;
      captured_d = captured_q | w_capture;
    end
  end

  always_comb begin
    hex_d        = hex_q;
    dp_d         = dp_q;
    valid_d      = valid_q;
    w_seen_nx    = seen_q;
    w_bad_nx     = bad_q;
    seen_d       = seen_q;
    bad_d        = bad_q;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    if (w_capture) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (w_sel[i]) begin
          dp_d[i]    = sseg_q[7];
          valid_d[i] = w_dec[4];
          if (w_dec[4]) begin
            hex_d[4*i +: 4] = w_dec[3:0];
          end
        end
      end
      w_seen_nx = seen_q | w_sel;
      w_bad_nx  = bad_q | (w_dec[4] ? '0 : w_sel);
      seen_d    = w_seen_nx;
      bad_d     = w_bad_nx;
      if (w_seen_nx == C_ALL) begin
        frame_done_d = 1'b1;
        frame_err_d  = |w_bad_nx;
        seen_d       = '0;
        bad_d        = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q         <= '1;
      sseg_q       <= '1;
      key_prev_q   <= '1;
      cnt_q        <= 8'd0;
      captured_q   <= 1'b0;
      seen_q       <= '0;
      bad_q        <= '0;
      hex_q        <= '0;
      dp_q         <= '1;
      valid_q      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      an_q         <= an_in;
      sseg_q       <= sseg_in;
      key_prev_q   <= w_key;
      cnt_q        <= cnt_d;
      captured_q   <= captured_d;
      seen_q       <= seen_d;
      bad_q        <= bad_d;
      hex_q        <= hex_d;
      dp_q         <= dp_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign hex_out     = hex_q;
  assign dp_out      = dp_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_capture.sv
`default_nettype none
// ============================================================================
// tb_sseg_capture : scoreboard bench with a run-length reference model
// Revision 1.0 - initial release
// ============================================================================
module tb_sseg_capture;

  localparam int N = 3;
  localparam int S = 4;

  typedef struct packed {
    logic [4*N-1:0] hex;
    logic [N-1:0]   dp;
    logic [N-1:0]   valid;
    logic           fd;
    logic           fe;
  } out_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   an_in = '1;
  logic [7:0]     sseg_in = 8'hFF;
  logic [4*N-1:0] hex_out;
  logic [N-1:0]   dp_out;
  logic [N-1:0]   digit_valid;
  logic           frame_done;
  logic           frame_err;

  sseg_capture #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .an_in      (an_in),
    .sseg_in    (sseg_in),
    .hex_out    (hex_out),
    .dp_out     (dp_out),
    .digit_valid(digit_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   fd_cnt   = 0;
  logic mon_en   = 1'b0;
  out_t exp_q[$];

  logic [6:0] pat_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference model: outputs follow from the length of the current run of
  // identical single-digit samples; a digit is taken when the run reaches S.
  out_t       m_st;
  int         m_run;
  logic [N-1:0] m_prev_an;
  logic [7:0] m_prev_ss;
  logic [N-1:0] m_seen;
  logic       m_bad;

  task automatic model_reset();
    m_st.hex   = '0;
    m_st.dp    = '1;
    m_st.valid = '0;
    m_st.fd    = 1'b0;
    m_st.fe    = 1'b0;
    m_run      = 0;
    m_prev_an  = '1;
    m_prev_ss  = 8'hFF;
    m_seen     = '0;
    m_bad      = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] an, input logic [7:0] ss);
    int   zeros = 0;
    int   d = 0;
    bit   found = 0;
    int   val = 0;
    for (int i = 0; i < N; i++) if (an[i] == 1'b0) begin zeros++; d = i; end
    if (zeros == 1 && an == m_prev_an && ss == m_prev_ss) m_run++;
    else m_run = (zeros == 1) ? 1 : 0;
    m_st.fd = 1'b0;
    if (m_run == S) begin
      for (int p = 0; p < 16; p++) if (pat_tab[p] == ss[6:0]) begin found = 1; val = p; end
      if (found) begin
        m_st.hex[4*d +: 4] = 4'(val);
        m_st.valid[d] = 1'b1;
      end else begin
        m_st.valid[d] = 1'b0;
        m_bad = 1'b1;
      end
      m_st.dp[d] = ss[7];
      m_seen[d]  = 1'b1;
      if (m_seen == '1) begin
        m_st.fd = 1'b1;
        m_st.fe = m_bad;
        m_seen  = '0;
        m_bad   = 1'b0;
      end
    end
    m_prev_an = an;
    m_prev_ss = ss;
    exp_q.push_back(m_st);
  endtask

  task automatic drive(input logic [N-1:0] an, input logic [7:0] ss);
    an_in   = an;
    sseg_in = ss;
    model_step(an, ss);
    @(negedge clk);
  endtask

  task automatic hold(input logic [N-1:0] an, input logic [7:0] ss, input int n);
    repeat (n) drive(an, ss);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    exp_q.delete();
    reset   = 1'b1;
    an_in   = '1;
    sseg_in = 8'hFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.push_back(m_st);
    mon_en = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per clock, sampled just after the edge.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      out_t act;
      out_t exp;
      act = '{hex: hex_out, dp: dp_out, valid: digit_valid, fd: frame_done, fe: frame_err};
      if (frame_done === 1'b1) fd_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard_empty: got output %h expected an entry", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_errors++;
          $display("FAIL cycle_outputs @%0t: got hex=%h dp=%b v=%b fd=%b fe=%b expected hex=%h dp=%b v=%b fd=%b fe=%b",
                   $time, act.hex, act.dp, act.valid, act.fd, act.fe,
                   exp.hex, exp.dp, exp.valid, exp.fd, exp.fe);
        end
      end
    end
  end

  initial begin
    int fd0;
    @(negedge clk);
    do_reset();
    chk("reset_hex", 32'(hex_out), 32'h0);
    chk("reset_dp", 32'(dp_out), 32'h7);

    // Single digit held exactly long enough to be captured.
    hold(3'b110, 8'b1_0010010, 5);
    chk("t1_hex0", 32'(hex_out[3:0]), 32'h2);
    chk("t1_dp0", 32'(dp_out[0]), 32'h1);
    chk("t1_valid", 32'(digit_valid), 32'h1);
    chk("t1_fd", 32'(frame_done), 32'h0);

    // Full legal scan.
    fd0 = fd_cnt;
    hold(3'b110, 8'b1_0000110, 6);
    hold(3'b101, 8'b0_0111000, 6);
    hold(3'b011, 8'b1_1100000, 6);
    chk("t2_hex", 32'(hex_out), 32'hBF3);
    chk("t2_dp", 32'(dp_out), 32'h5);
    chk("t2_fd_count", 32'(fd_cnt - fd0), 32'h1);
    chk("t2_fe", 32'(frame_err), 32'h0);

    // Blank digit 1 is an illegal capture.
    hold(3'b110, 8'b1_0000110, 6);
    hold(3'b101, 8'b1_1111111, 6);
    hold(3'b011, 8'b1_1100000, 6);
    chk("t3_valid", 32'(digit_valid), 32'h5);
    chk("t3_hex1_held", 32'(hex_out[7:4]), 32'hF);
    chk("t3_fe", 32'(frame_err), 32'h1);

    // One-cycle glitch restarts the dwell.
    hold(3'b110, 8'b1_1001111, 3);
    hold(3'b110, 8'b1_0000000, 1);
    hold(3'b110, 8'b1_1001111, 3);
    chk("t4_no_capture_hex0", 32'(hex_out[3:0]), 32'h3);
    chk("t4_no_capture_valid", 32'(digit_valid), 32'h5);
    hold(3'b110, 8'b1_1001111, 4);
    chk("t4_capture_hex0", 32'(hex_out[3:0]), 32'h1);

    // Ineligible digit enables.
    fd0 = fd_cnt;
    hold(3'b100, 8'b1_0000000, 20);
    hold(3'b111, 8'b1_0000000, 20);
    chk("t5_hex_unchanged", 32'(hex_out), 32'hBF1);
    chk("t5_no_fd", 32'(fd_cnt - fd0), 32'h0);

    // Reset mid-frame, then one clean frame.
    hold(3'b110, 8'b1_0100100, 6);
    hold(3'b101, 8'b1_0001000, 6);
    do_reset();
    chk("t6_reset_hex", 32'(hex_out), 32'h0);
    chk("t6_reset_dp", 32'(dp_out), 32'h7);
    chk("t6_reset_valid", 32'(digit_valid), 32'h0);
    fd0 = fd_cnt;
    hold(3'b011, 8'b0_0110001, 6);
    hold(3'b110, 8'b1_1000010, 6);
    hold(3'b101, 8'b1_0110000, 6);
    hold(3'b111, 8'hFF, 2);
    chk("t6_one_fd", 32'(fd_cnt - fd0), 32'h1);
    chk("t6_hex", 32'(hex_out), 32'hCED);

    // Randomised dwells, glitches and illegal patterns.
    for (int k = 0; k < 300; k++) begin
      logic [N-1:0] an;
      logic [7:0]   ss;
      int           r;
      r  = $urandom_range(0, 9);
      an = 3'b111;
      if (r < 7) an[$urandom_range(0, N - 1)] = 1'b0;
      else if (r == 7) an = 3'($urandom_range(0, 7));
      ss[7]   = 1'($urandom_range(0, 1));
      ss[6:0] = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(0, 127))
                                            : pat_tab[$urandom_range(0, 15)];
      hold(an, ss, $urandom_range(1, 7));
    end
    hold(3'b111, 8'hFF, 2);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
